// File: rtl/cdce62002_pkg.sv
// rtl/cdce62002_pkg.sv - shared constants and FSM state type for the CDCE62002 register port
//
// Purpose: frame width, register-port command addresses and the frame FSM state
// encoding. The programming master imports this package as well.
package cdce62002_pkg;

  localparam int WORD_BITS = 32;

  localparam logic [3:0] ADDR_REG0  = 4'h0;
  localparam logic [3:0] ADDR_REG1  = 4'h1;
  localparam logic [3:0] ADDR_READ  = 4'hE;
  localparam logic [3:0] ADDR_STORE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with registered-edge rise/fall pulses
//
// Purpose: brings one asynchronous pin into the clk domain and flags its edges.
// Ports:
//   clk, reset_n  system clock, asynchronous active-low reset
//   din           asynchronous input pin
//   level         synchronised level (STAGES flops after din)
//   rise, fall    one-clk pulses on a synchronised 0->1 / 1->0 transition
//
// Everything resets to 0, so a pin held low through reset release never
// produces a spurious falling edge (a frame cut by reset is not re-entered).
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/cdce62002_spi_responder.sv
// rtl/cdce62002_spi_responder.sv - target-side CDCE62002 register-port model
//
// Purpose: receives LE-framed 32-bit words (LSB first, addr [3:0], data [31:4])
// and maintains RAM registers reg0/reg1, their EEPROM shadows nv0/nv1 and the
// readback shifter that drives spi_miso.
// Ports:
//   clk, reset_n       system clock, asynchronous active-low reset
//   spi_clk, spi_le,   asynchronous config bus from the master (spi_clk <= clk/4)
//   spi_mosi
//   spi_miso           readback data, advanced after each spi_clk fall
//   reg0, reg1         RAM register data fields
//   nv0, nv1           EEPROM shadow copies
//   reg_update         one-clk pulse per register written (bit i = reg i)
//   eeprom_store       one-clk pulse on a committed store command
//   frame_error        one-clk pulse when a frame ends with a bit count other than WORD_BITS
//   busy               high while a frame is being shifted
module cdce62002_spi_responder
  import cdce62002_pkg::*;
#(
  parameter int               WORD_BITS   = 32,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WORD_BITS-5:0] REG0_INIT = '0,
  parameter logic [WORD_BITS-5:0] REG1_INIT = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_clk,
  input  logic                 spi_le,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic [WORD_BITS-5:0] reg0,
  output logic [WORD_BITS-5:0] reg1,
  output logic [WORD_BITS-5:0] nv0,
  output logic [WORD_BITS-5:0] nv1,
  output logic [1:0]           reg_update,
  output logic                 eeprom_store,
  output logic                 frame_error,
  output logic                 busy
);

  localparam logic [5:0] CNT_FULL = 6'(WORD_BITS);
  localparam logic [5:0] CNT_SAT  = 6'(WORD_BITS + 1);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic le_rise, le_fall, le_level_unused;
  logic mosi, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .din(spi_clk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_le (
    .clk(clk), .reset_n(reset_n), .din(spi_le),
    .level(le_level_unused), .rise(le_rise), .fall(le_fall)
  );

  // mosi shares the sclk pipeline depth, so its level lines up with sclk_rise.
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .din(spi_mosi),
    .level(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t                 state, next_state;
  logic [5:0]             bit_cnt;
  logic [WORD_BITS-1:0]   shift_in;
  logic [WORD_BITS-1:0]   out_shift;
  logic                   read_pending;
  logic                   read_target;
  logic                   read_frame;

  logic [3:0]             word_addr;
  logic [WORD_BITS-5:0]   word_data;
  logic [WORD_BITS-5:0]   read_data;

  assign word_addr = shift_in[3:0];
  assign word_data = shift_in[WORD_BITS-1:4];
  assign read_data = read_target ? reg1 : reg0;

  // Zeros are shifted in behind the readback word, so miso falls to 0 by
  // itself once all WORD_BITS bits have gone out.
  assign spi_miso = out_shift[0];
  assign busy     = (state == SHIFT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (le_fall) next_state = SHIFT;
      SHIFT:   if (le_rise) next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt      <= '0;
      shift_in     <= '0;
      out_shift    <= '0;
      read_pending <= 1'b0;
      read_target  <= 1'b0;
      read_frame   <= 1'b0;
      reg0         <= REG0_INIT;
      reg1         <= REG1_INIT;
      nv0          <= REG0_INIT;
      nv1          <= REG1_INIT;
      reg_update   <= 2'b00;
      eeprom_store <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      reg_update   <= 2'b00;
      eeprom_store <= 1'b0;
      frame_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (le_fall) begin
            bit_cnt    <= '0;
            shift_in   <= '0;
            read_frame <= read_pending;
            out_shift  <= read_pending ? {read_data, 3'b000, read_target} : '0;
          end
        end
        SHIFT: begin
          // A same-clk le rise moves to COMMIT, where this bit is already in.
          if (sclk_rise) begin
            shift_in <= {mosi, shift_in[WORD_BITS-1:1]};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 6'd1;
          end
          if (sclk_fall) out_shift <= out_shift >> 1;
        end
        COMMIT: begin
          out_shift  <= '0;
          read_frame <= 1'b0;
          // A readback frame retires the pending read whatever its length;
          // a read command decoded below in the same frame re-arms it.
          if (read_frame) read_pending <= 1'b0;
          if (bit_cnt == CNT_FULL) begin
            case (word_addr)
              ADDR_REG0: begin
                reg0       <= word_data;
                reg_update <= 2'b01;
              end
              ADDR_REG1: begin
                reg1       <= word_data;
                reg_update <= 2'b10;
              end
              ADDR_READ: begin
                read_pending <= 1'b1;
                read_target  <= shift_in[4];
              end
              ADDR_STORE: begin
                nv0          <= reg0;
                nv1          <= reg1;
                eeprom_store <= 1'b1;
              end
              default: ;
            endcase
          end else begin
            frame_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cdce62002_spi_responder.sv
// tb/tb_cdce62002_spi_responder.sv - self-checking bench for cdce62002_spi_responder
module tb_cdce62002_spi_responder;

  localparam logic [27:0] I0   = 28'h1234567;
  localparam logic [27:0] I1   = 28'h0ABCDEF;
  localparam int          HALF = 60;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_le = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [27:0] reg0, reg1, nv0, nv1;
  logic [1:0]  reg_update;
  logic        eeprom_store, frame_error, busy;

  int checks = 0;
  int errors = 0;
  int tot_u0 = 0, tot_u1 = 0, tot_st = 0, tot_er = 0;

  always #5 clk = ~clk;

  cdce62002_spi_responder #(
    .WORD_BITS(32), .SYNC_STAGES(2), .REG0_INIT(I0), .REG1_INIT(I1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_le(spi_le),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .reg0(reg0), .reg1(reg1),
    .nv0(nv0), .nv1(nv1), .reg_update(reg_update), .eeprom_store(eeprom_store),
    .frame_error(frame_error), .busy(busy)
  );

  always @(negedge clk) begin
    if (reg_update[0]) tot_u0++;
    if (reg_update[1]) tot_u1++;
    if (eeprom_store)  tot_st++;
    if (frame_error)   tot_er++;
  end

  // Reference: the two RAM registers, their shadows and the pending read.
  logic [27:0] m_reg [2];
  logic [27:0] m_nv  [2];
  logic        m_rp, m_tgt;

  task automatic model_reset();
    m_reg[0] = I0; m_reg[1] = I1;
    m_nv[0]  = I0; m_nv[1]  = I1;
    m_rp = 1'b0; m_tgt = 1'b0;
  endtask

  task automatic model_frame(input logic [63:0] w, input int n, output logic [31:0] em,
                             output logic [1:0] eu, output logic es, output logic ee);
    em = m_rp ? {m_reg[m_tgt], 3'b000, m_tgt} : 32'h0;
    eu = 2'b00; es = 1'b0; ee = 1'b0;
    m_rp = 1'b0;
    if (n != 32) begin
      ee = 1'b1;
    end else begin
      case (w[3:0])
        4'h0: begin m_reg[0] = w[31:4]; eu = 2'b01; end
        4'h1: begin m_reg[1] = w[31:4]; eu = 2'b10; end
        4'hE: begin m_rp = 1'b1; m_tgt = w[4]; end
        4'hF: begin m_nv[0] = m_reg[0]; m_nv[1] = m_reg[1]; es = 1'b1; end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [63:0] w, input int n, output logic [31:0] cap);
    cap = '0;
    spi_le = 1'b0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = w[i];
      #HALF;
      if (i < 32) cap[i] = spi_miso;
      spi_clk = 1'b1;
      #HALF;
      spi_clk = 1'b0;
    end
    #HALF;
    spi_le = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input logic [63:0] w, input int n,
                           input logic [31:0] em, input logic [1:0] eu, input logic es,
                           input logic ee, input logic [27:0] e0, input logic [27:0] e1,
                           input logic [27:0] en0, input logic [27:0] en1);
    logic [31:0] cap, mask;
    int u0, u1, s, e;
    u0 = tot_u0; u1 = tot_u1; s = tot_st; e = tot_er;
    send_frame(w, n, cap);
    mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    chk({tag, ".miso"}, cap & mask, em & mask);
    chk({tag, ".reg0"}, 32'(reg0), 32'(e0));
    chk({tag, ".reg1"}, 32'(reg1), 32'(e1));
    chk({tag, ".nv0"}, 32'(nv0), 32'(en0));
    chk({tag, ".nv1"}, 32'(nv1), 32'(en1));
    chk({tag, ".upd0"}, 32'(tot_u0 - u0), 32'(eu[0]));
    chk({tag, ".upd1"}, 32'(tot_u1 - u1), 32'(eu[1]));
    chk({tag, ".store"}, 32'(tot_st - s), 32'(es));
    chk({tag, ".ferr"}, 32'(tot_er - e), 32'(ee));
    chk({tag, ".busy"}, 32'(busy), 32'h0);
  endtask

  typedef struct {
    logic [63:0] word;
    int          nbits;
    logic [31:0] miso;
    logic [1:0]  upd;
    logic        st;
    logic        err;
    logic [27:0] r0, r1, n0, n1;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] em, cap;
    logic [1:0]  eu;
    logic        es, ee;
    logic [63:0] w;
    logic [3:0]  a;
    int          n, u0, u1, s, e;

    vecs[0] = '{64'h55D00080, 32, 32'h0,        2'b01, 1'b0, 1'b0, 28'h55D0008, I1, I0, I1};
    vecs[1] = '{64'h8383E001, 32, 32'h0,        2'b10, 1'b0, 1'b0, 28'h55D0008, 28'h8383E00, I0, I1};
    vecs[2] = '{64'h0000001E, 32, 32'h0,        2'b00, 1'b0, 1'b0, 28'h55D0008, 28'h8383E00, I0, I1};
    vecs[3] = '{64'h12345673, 32, 32'h8383E001, 2'b00, 1'b0, 1'b0, 28'h55D0008, 28'h8383E00, I0, I1};
    vecs[4] = '{64'hFFFFFFF0, 31, 32'h0,        2'b00, 1'b0, 1'b1, 28'h55D0008, 28'h8383E00, I0, I1};
    vecs[5] = '{64'h100000000, 33, 32'h0,       2'b00, 1'b0, 1'b1, 28'h55D0008, 28'h8383E00, I0, I1};
    vecs[6] = '{64'h0000000F, 32, 32'h0,        2'b00, 1'b1, 1'b0, 28'h55D0008, 28'h8383E00,
                28'h55D0008, 28'h8383E00};

    model_reset();
    #13;
    chk("rst.reg0", 32'(reg0), 32'(I0));
    chk("rst.reg1", 32'(reg1), 32'(I1));
    chk("rst.nv0", 32'(nv0), 32'(I0));
    chk("rst.nv1", 32'(nv1), 32'(I1));
    chk("rst.miso", 32'(spi_miso), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    #10;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    for (int k = 0; k < 7; k++) begin
      model_frame(vecs[k].word, vecs[k].nbits, em, eu, es, ee);
      run_frame($sformatf("vec%0d", k), vecs[k].word, vecs[k].nbits, vecs[k].miso,
                vecs[k].upd, vecs[k].st, vecs[k].err, vecs[k].r0, vecs[k].r1,
                vecs[k].n0, vecs[k].n1);
    end

    // Arm a read of reg0, then cut the readback frame with reset at bit 17.
    model_frame(64'h0000000E, 32, em, eu, es, ee);
    run_frame("arm", 64'h0000000E, 32, em, eu, es, ee, m_reg[0], m_reg[1], m_nv[0], m_nv[1]);
    w = 64'h00000010;
    u0 = tot_u0; u1 = tot_u1; s = tot_st; e = tot_er;
    spi_le = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 17) begin
        chk("mid.busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #20;
        chk("mid.reg0", 32'(reg0), 32'(I0));
        chk("mid.reg1", 32'(reg1), 32'(I1));
        chk("mid.nv0", 32'(nv0), 32'(I0));
        chk("mid.nv1", 32'(nv1), 32'(I1));
        chk("mid.pulses", {28'h0, reg_update, eeprom_store, frame_error}, 32'h0);
        chk("mid.rbusy", 32'(busy), 32'h0);
        chk("mid.miso", 32'(spi_miso), 32'h0);
        reset_n = 1'b1;
        model_reset();
      end
      spi_mosi = w[i];
      #HALF;
      spi_clk = 1'b1;
      #HALF;
      spi_clk = 1'b0;
    end
    #HALF;
    spi_le = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("stray.pulses", 32'(tot_u0 - u0 + tot_u1 - u1 + tot_st - s + tot_er - e), 32'h0);
    chk("stray.reg0", 32'(reg0), 32'(I0));
    chk("stray.busy", 32'(busy), 32'h0);
    model_frame(64'h55D00080, 32, em, eu, es, ee);
    run_frame("post", 64'h55D00080, 32, em, eu, es, ee, m_reg[0], m_reg[1], m_nv[0], m_nv[1]);

    for (int k = 0; k < 40; k++) begin
      w = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: a = 4'h0;
        1: a = 4'h1;
        2, 5: a = 4'hE;
        3: a = 4'hF;
        default: a = 4'($urandom_range(2, 13));
      endcase
      w[3:0] = a;
      case ($urandom_range(0, 9))
        0: n = 31;
        1: n = 33;
        default: n = 32;
      endcase
      model_frame(w, n, em, eu, es, ee);
      run_frame($sformatf("rnd%0d", k), w, n, em, eu, es, ee,
                m_reg[0], m_reg[1], m_nv[0], m_nv[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
